// File: rtl/hazard_pkg.sv
// Shared widths, types and the per-source hazard test for the D-stage stall logic.
package hazard_pkg;

  localparam int REG_W    = 5;
  localparam int T_W      = 2;
  localparam int MD_CNT_W = 4;

  typedef logic [REG_W-1:0] reg_t;
  typedef logic [T_W-1:0]   tval_t;

  localparam tval_t TUSE_NONE = 2'd3;

  // E and M are OR-ed here; E-over-M priority only matters to forwarding.
  function automatic logic src_hazard(
    input reg_t  src,
    input tval_t tuse,
    input reg_t  e_a3,
    input tval_t e_tnew,
    input reg_t  m_a3,
    input tval_t m_tnew
  );
    return (src != '0) && (tuse != TUSE_NONE) &&
           (((src == e_a3) && (tuse < e_tnew)) ||
            ((src == m_a3) && (tuse < m_tnew)));
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Down-counter tracking the multiply/divide busy window; busy while nonzero.
module md_busy_counter
  import hazard_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [MD_CNT_W-1:0] value,
  input  logic                dec,
  output logic                busy
);

  logic [MD_CNT_W-1:0] md_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_reg <= '0;
    end else if (load) begin
      md_cnt_reg <= value;
    end else if (dec && (md_cnt_reg != '0)) begin
      md_cnt_reg <= md_cnt_reg - MD_CNT_W'(1);
    end
  end

  assign busy = (md_cnt_reg != '0);

endmodule

// File: rtl/hazard_unit.sv
// Stall generation from shadow E/M dest/Tnew vs. D-stage Tuse.
// Define HAZARD_MD_STALL_EN to also stall HI/LO accesses during a mult/div busy window.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_tuse_rs,
  input  logic [1:0]  D_tuse_rt,
  input  logic [4:0]  D_a3,
  input  logic [1:0]  D_tnew,
  input  logic        D_md_start,
  input  logic        D_md_div,
  input  logic        D_md_use,
  output logic        stall
);

  reg_t  e_a3_reg, m_a3_reg;
  tval_t e_tnew_reg, m_tnew_reg;

  reg_t  src  [2];
  tval_t tuse [2];
  logic [1:0] hz;
  logic md_hz;

  assign src[0]  = D_rs;
  assign src[1]  = D_rt;
  assign tuse[0] = D_tuse_rs;
  assign tuse[1] = D_tuse_rt;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign hz[gi] = src_hazard(src[gi], tuse[gi], e_a3_reg, e_tnew_reg,
                                 m_a3_reg, m_tnew_reg);
    end
  endgenerate

  assign stall = ~reset & ((|hz) | md_hz);

  always_ff @(posedge clk) begin
    if (reset) begin
      e_a3_reg   <= '0;
      e_tnew_reg <= '0;
      m_a3_reg   <= '0;
      m_tnew_reg <= '0;
    end else begin
      if (stall) begin
        e_a3_reg   <= '0;
        e_tnew_reg <= '0;
      end else begin
        e_a3_reg   <= D_a3;
        e_tnew_reg <= D_tnew;
      end
      m_a3_reg   <= e_a3_reg;
      m_tnew_reg <= (e_tnew_reg == '0) ? '0 : e_tnew_reg - T_W'(1);
    end
  end

`ifdef HAZARD_MD_STALL_EN
  logic e_md_reg, e_div_reg;
  logic md_busy;
  logic [MD_CNT_W-1:0] md_load_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      e_md_reg  <= 1'b0;
      e_div_reg <= 1'b0;
    end else begin
      e_md_reg  <= ~stall & D_md_start;
      e_div_reg <= ~stall & D_md_start & D_md_div;
    end
  end

  // The busy window starts when the op executes in E; e_md_reg covers the issue cycle itself.
  assign md_load_val = e_div_reg ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);

  md_busy_counter u_md_busy (
    .clk   (clk),
    .reset (reset),
    .load  (e_md_reg),
    .value (md_load_val),
    .dec   (1'b1),
    .busy  (md_busy)
  );

  assign md_hz = (D_md_use & (md_busy | e_md_reg)) | (D_md_start & md_busy);
`else
  logic unused_md;
  assign unused_md = ^{D_md_start, D_md_div, D_md_use, 1'(MULT_CYCLES), 1'(DIV_CYCLES)};
  assign md_hz = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: vector table, reset-mid-stall and mult/div sequences.
module tb_hazard_unit;

  localparam int MULT_C = 5;
  localparam int DIV_C  = 10;
`ifdef HAZARD_MD_STALL_EN
  localparam int EXP_DIV  = DIV_C + 1;
  localparam int EXP_MULT = MULT_C + 1;
`else
  localparam int EXP_DIV  = 0;
  localparam int EXP_MULT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] d_rs = '0, d_rt = '0, d_a3 = '0;
  logic [1:0] d_tuse_rs = 2'd3, d_tuse_rt = 2'd3, d_tnew = '0;
  logic       d_md_start = 1'b0, d_md_div = 1'b0, d_md_use = 1'b0;
  logic       stall;

  hazard_unit #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C)) dut (
    .clk        (clk),
    .reset      (rst),
    .D_rs       (d_rs),
    .D_rt       (d_rt),
    .D_tuse_rs  (d_tuse_rs),
    .D_tuse_rt  (d_tuse_rt),
    .D_a3       (d_a3),
    .D_tnew     (d_tnew),
    .D_md_start (d_md_start),
    .D_md_div   (d_md_div),
    .D_md_use   (d_md_use),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] rs;
    logic [1:0] tr;
    logic [4:0] rt;
    logic [1:0] tt;
    logic [4:0] a3;
    logic [1:0] tn;
    logic       ms, md, mu;
    logic       st;   // expected stall this cycle
    logic [4:0] ea;   // expected E dest after the edge
  } vec_t;

  typedef struct {
    logic       stall;
    logic [4:0] e_a3;
    logic [4:0] m_a3;
  } exp_t;

  exp_t sb[$];
  vec_t vec[28];
  int total = 0;
  int bad   = 0;
  int txn   = 0;
  logic [4:0] prev_ea = '0;

  function automatic vec_t mk(logic r, logic [4:0] rs, logic [1:0] tr, logic [4:0] rt,
                              logic [1:0] tt, logic [4:0] a3, logic [1:0] tn,
                              logic ms, logic md, logic mu, logic st, logic [4:0] ea);
    vec_t v;
    v.rst = r; v.rs = rs; v.tr = tr; v.rt = rt; v.tt = tt; v.a3 = a3; v.tn = tn;
    v.ms = ms; v.md = md; v.mu = mu; v.st = st; v.ea = ea;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s txn=%0d got=%0d want=%0d", name, txn, act, want);
    end
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    rst = v.rst; d_rs = v.rs; d_tuse_rs = v.tr; d_rt = v.rt; d_tuse_rt = v.tt;
    d_a3 = v.a3; d_tnew = v.tn; d_md_start = v.ms; d_md_div = v.md; d_md_use = v.mu;
    e.stall = v.st;
    e.e_a3  = v.ea;
    e.m_a3  = v.rst ? 5'd0 : prev_ea;
    prev_ea = v.ea;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk("stall", int'(stall), int'(e.stall));
    @(posedge clk);
    #1;
    chk("e_a3", int'(dut.e_a3_reg), int'(e.e_a3));
    chk("m_a3", int'(dut.m_a3_reg), int'(e.m_a3));
    $display("txn %0d rst=%0b rs=%0d/%0d rt=%0d/%0d a3=%0d tnew=%0d md=%0b%0b%0b stall=%0b e_a3=%0d m_a3=%0d",
             txn, v.rst, v.rs, v.tr, v.rt, v.tt, v.a3, v.tn, v.ms, v.md, v.mu,
             e.stall, dut.e_a3_reg, dut.m_a3_reg);
    txn++;
  endtask

  task automatic md_seq(input logic is_div, input int exp_cycles, input int span);
    step(mk(0, 0, 3, 0, 3, 0, 0, 1, is_div, 0, 0, 0));
    for (int i = 0; i < span; i++)
      step(mk(0, 0, 3, 0, 3, 0, 0, 0, 0, 1, (i < exp_cycles), 0));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    //            rst rs tr rt tt a3 tn ms md mu st ea
    vec[0]  = mk(1,  0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    vec[1]  = mk(1,  1, 0, 1, 0, 1, 2, 0, 0, 0, 0, 0);
    vec[2]  = mk(0,  5, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    vec[3]  = mk(0,  0, 3, 0, 3, 1, 2, 0, 0, 0, 0, 1);   // lw $1
    vec[4]  = mk(0,  1, 0, 2, 0, 3, 1, 0, 0, 0, 1, 0);   // add uses $1 at Tuse 0
    vec[5]  = mk(0,  1, 0, 2, 0, 3, 1, 0, 0, 0, 1, 0);
    vec[6]  = mk(0,  1, 0, 2, 0, 3, 1, 0, 0, 0, 0, 3);
    vec[7]  = mk(0,  0, 3, 0, 3, 4, 2, 0, 0, 0, 0, 4);   // lw $4
    vec[8]  = mk(0,  0, 0, 4, 1, 0, 0, 0, 0, 0, 1, 0);   // Tuse 1 -> one stall
    vec[9]  = mk(0,  0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    vec[10] = mk(0,  0, 3, 0, 3, 1, 1, 0, 0, 0, 0, 1);
    vec[11] = mk(0,  2, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0);   // sw, Tuse 2 never stalls
    vec[12] = mk(0,  2, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    vec[13] = mk(0,  0, 3, 0, 3, 0, 2, 0, 0, 0, 0, 0);   // writes $0
    vec[14] = mk(0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vec[15] = mk(0,  0, 3, 0, 3, 7, 2, 0, 0, 0, 0, 7);
    vec[16] = mk(0,  7, 3, 7, 3, 0, 0, 0, 0, 0, 0, 0);   // Tuse 3 = unused
    vec[17] = mk(0,  0, 3, 0, 3, 8, 2, 0, 0, 0, 0, 8);
    vec[18] = mk(0,  0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    vec[19] = mk(0,  8, 0, 0, 3, 5, 0, 0, 0, 0, 1, 0);   // M-only hazard
    vec[20] = mk(0,  8, 0, 0, 3, 5, 0, 0, 0, 0, 0, 5);
    vec[21] = mk(0,  0, 3, 0, 3, 9, 1, 0, 0, 0, 0, 9);
    vec[22] = mk(0,  0, 3, 9, 0, 0, 0, 0, 0, 0, 1, 0);   // rt-only hazard
    vec[23] = mk(0,  0, 3, 9, 0, 0, 0, 0, 0, 0, 0, 0);
    vec[24] = mk(0,  0, 3, 0, 3, 10, 2, 0, 0, 0, 0, 10);
    vec[25] = mk(0,  0, 3, 0, 3, 10, 2, 0, 0, 0, 0, 10);
    vec[26] = mk(0, 10, 1, 10, 1, 0, 0, 0, 0, 0, 1, 0);  // same reg in E and M
    vec[27] = mk(0, 10, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0);

    @(posedge clk);
    #1;
    for (int i = 0; i < 28; i++) step(vec[i]);

    // reset lands on the first stall cycle of a load-use pair
    step(mk(0, 0, 3, 0, 3, 1, 2, 0, 0, 0, 0, 1));
    step(mk(1, 1, 0, 0, 3, 3, 1, 0, 0, 0, 0, 0));
    step(mk(0, 1, 0, 0, 3, 3, 1, 0, 0, 0, 0, 3));
    step(mk(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0));

    md_seq(1'b1, EXP_DIV, DIV_C + 3);
    step(mk(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0));
    md_seq(1'b0, EXP_MULT, MULT_C + 3);

    // reset right after a div issue clears the busy window
    step(mk(0, 0, 3, 0, 3, 0, 0, 1, 1, 0, 0, 0));
    step(mk(1, 0, 3, 0, 3, 0, 0, 0, 0, 1, 0, 0));
    step(mk(0, 0, 3, 0, 3, 0, 0, 0, 0, 1, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Stall-generation stage of the 5-stage MIPS pipeline, directly upstream of the stall controller: it produces the single `stall` bit that the controller turns into PC-enable, D-register-enable and E-register-clear. It keeps its own shadow pipeline of destination register and Tnew for the E and M stages, and compares these against the Tuse of the instruction in D. Optionally, it tracks a multiply/divide busy window and stalls HI/LO accesses during it.

## Interface
- `MULT_CYCLES`, default 5: busy cycles loaded for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles loaded for div/divu.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `D_rs`, `D_rt`  in  5 each: source register numbers of the D-stage instruction.
- `D_tuse_rs`, `D_tuse_rt`  in  2 each: cycles from D until the operand is needed (0..2); 3 means the operand is unused.
- `D_a3`  in  5: destination register of the D instruction; 0 means no write.
- `D_tnew`  in  2: cycles after entering E until the result is forwardable (0..2).
- `D_md_start`  in  1: D instruction is mult/multu/div/divu.
- `D_md_div`  in  1: qualifies `D_md_start`; 1 selects div.
- `D_md_use`  in  1: D instruction is mfhi/mflo/mthi/mtlo.
- `stall`  out  1: combinational stall request to the stall controller.

## Operation
- State:
  - `E_a3`/`E_tnew` (5/2 bits).
  - `M_a3`/`M_tnew` (5/2 bits).
  - `md_cnt` (4 bits, must hold `DIV_CYCLES`).
- Shadow pipeline update on each non-reset edge:
  - If `stall`=1: E is loaded with a bubble (`E_a3`=0, `E_tnew`=0).
  - Otherwise: E is loaded with `D_a3`/`D_tnew`.
  - M always loads `E_a3` and `E_tnew`-1, saturating at 0.
  - The W stage is not tracked; Tnew there is always 0 and is fully covered by forwarding.
- Register hazard, computed per source `s` in {rs, rt}:
  - `hz_s` = (`D_s` != 0) and (`D_tuse_s` != 3) and ((`D_s`==`E_a3` and `D_tuse_s` < `E_tnew`) or (`D_s`==`M_a3` and `D_tuse_s` < `M_tnew`)).
  - `stall` = `hz_rs` | `hz_rt` | `md_hz`.
- Register $0 never causes a stall, even when `E_a3`/`M_a3` is 0 after a bubble.
- Comparisons are unsigned on 2-bit values. Tuse=3 never stalls, because Tnew is at most 2.
- When the same register matches in both E and M, E takes precedence only for forwarding. For the stall decision, the two terms are simply OR-ed.

## Timing
- Reset values: `E_a3`=`M_a3`=0, `E_tnew`=`M_tnew`=0, `md_cnt`=0.
- `stall` is forced to 0 while `reset`=1. In the first cycle after reset, `stall` depends only on the D inputs and is 0 for any operands.
- `stall` has zero latency: it responds combinationally to the D inputs in the same cycle.
- A dependency that stalls holds D until the producer's Tnew reaches Tuse. Each stalled cycle inserts exactly one bubble into E.
- Load-use case (`D_tnew`=2 producer, Tuse=0 consumer) gives exactly 2 stall cycles. With consumer Tuse=1 it gives exactly 1.
- If reset is asserted mid-stall, all shadow state and `md_cnt` clear at that edge, and `stall` drops in the same cycle.

## Configuration
- Macro `HAZARD_MD_STALL_EN`.
- When defined:
  - On a non-stalled D->E transfer with `D_md_start`=1, `md_cnt` loads `DIV_CYCLES` if `D_md_div`, else `MULT_CYCLES`.
  - Otherwise `md_cnt` decrements each cycle, saturating at 0.
  - `md_hz` = `D_md_use` & ((`md_cnt` != 0) | (`E_md` start pending)), where `E_md` is a 1-bit register capturing the non-stalled `D_md_start`.
  - A new `D_md_start` while `md_cnt` != 0 also stalls.
- When undefined: `md_cnt` and `E_md` are not built, `md_hz`=0, and the `D_md_*` inputs are ignored.

## Structure
- Package `hazard_pkg` holds:
  - `TUSE_NONE`=2'd3
  - the register-number width of 5
  - the Tnew/Tuse width of 2
  - the `md_cnt` width
- One sub-module, `md_busy_counter` (load, value, decrement, busy), instantiated only under `HAZARD_MD_STALL_EN`.

## Test plan
- lw $1 producer (`D_a3`=1, `D_tnew`=2), then consumer add with `D_rs`=1, Tuse=0 -> `stall`=1 for 2 cycles, then 0; E shows bubble, bubble.
- Producer `D_a3`=1, `D_tnew`=1, then consumer sw with `D_rt`=1, Tuse=2 -> `stall` never asserts.
- Producer writing $0 with `D_tnew`=2, then consumer `D_rs`=0, Tuse=0 -> `stall`=0.
- Assert `reset` during the first stall cycle of the load-use case -> `stall`=0 in that cycle and `E_a3`=`M_a3`=0 after the edge.
- Under the macro: div issued, then mflo -> `stall` held for `DIV_CYCLES`+1 cycles, then released. mult gives `MULT_CYCLES`+1 cycles.
- Without the macro: the same div/mflo sequence -> `stall`=0 throughout.
